bram_in_pack: RTL and testbench

Write-side companion to the BRAM read-out path. Accepts a stream of 32-bit words over a valid/ready handshake and packs each pair into one 64-bit BRAM word: first word to [63:32], second word to [31:0]. This is the packing order the read-out path expects when it unpacks upper half first. Issues one BRAM write per packed pair at consecutive addresses from a per-burst start address. Pads an odd trailing word with zeros in [31:0].

---
 rtl/bram_in_pack.sv | 168 ++++++++++++++++
 tb/tb_bram_in_pack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_in_pack.sv
// ---------------------------------------------------------------------------
// bram_in_pack
// Write-side companion to the BRAM read-out path. Packs a stream of 32-bit
// words into 64-bit BRAM words (first word of each pair in [63:32], second
// in [31:0]) and writes them to consecutive addresses starting at a
// per-burst start address. An odd trailing word is padded with zeros in the
// lower half.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, start_addr  burst start request and first BRAM address (idle only)
//   s_data, s_valid,   input word stream with valid/ready handshake;
//   s_last, s_ready    s_last marks the final word of the burst
//   bram_en, bram_we   BRAM enable / write strobe (identical)
//   bram_addr,bram_din BRAM write address and 64-bit write data
//   busy               high from accepted start until done
//   done               one-cycle pulse at burst end
//   odd                last burst ended on a padded, unpaired word
//   wr_cnt             number of 64-bit writes in the last/current burst
// ---------------------------------------------------------------------------
module bram_in_pack #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [63:0]       bram_din,
    output logic              busy,
    output logic              done,
    output logic              odd,
    output logic [ADDR_W:0]   wr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [31:0]       hi_q,        hi_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [63:0]       bram_din_q,  bram_din_d;
    logic              bram_we_q,   bram_we_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              odd_q,       odd_d;
    logic [ADDR_W:0]   wr_cnt_q,    wr_cnt_d;

    logic              write_req;
    logic [63:0]       write_data;

    // s_ready depends on state only, so there is no path from s_valid.
    assign s_ready   = (state_q == HI) || (state_q == LO);
    assign bram_en   = bram_we_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign odd       = odd_q;
    assign wr_cnt    = wr_cnt_q;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        ptr_d       = ptr_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        odd_d       = odd_q;
        wr_cnt_d    = wr_cnt_q;
        write_req   = 1'b0;
        write_data  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d    = start_addr;
                    wr_cnt_d = '0;
                    odd_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = HI;
                end
            end
            HI: begin
                if (s_valid) begin
                    hi_d = s_data;
                    if (s_last) begin
                        // Unpaired final word: write it now, padded below.
                        write_req  = 1'b1;
                        write_data = {s_data, 32'h0000_0000};
                        odd_d      = 1'b1;
                        state_d    = FIN;
                    end else begin
                        state_d = LO;
                    end
                end
            end
            LO: begin
                if (s_valid) begin
                    write_req  = 1'b1;
                    write_data = {hi_q, s_data};
                    state_d    = s_last ? FIN : HI;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address and data registers only change on a write, so they hold
        // the last written values while bram_we is low.
        if (write_req) begin
            bram_we_d   = 1'b1;
            bram_addr_d = ptr_q;
            bram_din_d  = write_data;
            ptr_d       = ptr_q + 1'b1;
            if (!(&wr_cnt_q)) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            ptr_q       <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            odd_q       <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            ptr_q       <= ptr_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_we_q   <= bram_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            odd_q       <= odd_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

endmodule

// File: tb/tb_bram_in_pack.sv
// ---------------------------------------------------------------------------
// tb_bram_in_pack
// Self-checking bench for bram_in_pack. A behavioural model collects accepted
// words in a queue and forms the expected 64-bit writes from each completed
// pair (or padded final word); every output is compared each cycle.
// ---------------------------------------------------------------------------
module tb_bram_in_pack;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [31:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [63:0]       bram_din;
    logic              busy;
    logic              done;
    logic              odd;
    logic [ADDR_W:0]   wr_cnt;

    bram_in_pack #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .busy       (busy),
        .done       (done),
        .odd        (odd),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = idle, 1 = collecting words, 2 = finishing.
    int                m_phase = 0;
    logic [31:0]       m_pend[$];
    logic [ADDR_W-1:0] m_ptr  = '0;
    logic [ADDR_W:0]   m_cnt  = '0;
    logic              m_odd  = 1'b0;
    logic              m_busy = 1'b0;
    logic              m_we   = 1'b0;
    logic              m_done = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [63:0]       m_din  = '0;
    logic              last_accept = 1'b0;
    logic [31:0]       burst_words[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        checkOutput("s_ready",   64'(s_ready),   64'(m_phase == 1));
        checkOutput("bram_we",   64'(bram_we),   64'(m_we));
        checkOutput("bram_en",   64'(bram_en),   64'(m_we));
        checkOutput("bram_addr", 64'(bram_addr), 64'(m_addr));
        checkOutput("bram_din",  bram_din,       m_din);
        checkOutput("busy",      64'(busy),      64'(m_busy));
        checkOutput("done",      64'(done),      64'(m_done));
        checkOutput("odd",       64'(odd),       64'(m_odd));
        checkOutput("wr_cnt",    64'(wr_cnt),    64'(m_cnt));
    endtask

    // Drive one cycle of inputs (called at the falling edge), advance the
    // model to what the outputs should be after the next rising edge, then
    // compare at the following falling edge.
    task automatic applyStimulus(input logic st, input logic [ADDR_W-1:0] sa,
                                 input logic sv, input logic [31:0] sd, input logic sl);
        start      = st;
        start_addr = sa;
        s_valid    = sv;
        s_data     = sd;
        s_last     = sl;
        last_accept = 1'b0;
        m_we   = 1'b0;
        m_done = 1'b0;
        if (m_phase == 0) begin
            if (st) begin
                m_ptr   = sa;
                m_cnt   = '0;
                m_odd   = 1'b0;
                m_busy  = 1'b1;
                m_phase = 1;
                m_pend.delete();
            end
        end else if (m_phase == 1) begin
            if (sv) begin
                last_accept = 1'b1;
                m_pend.push_back(sd);
                if (m_pend.size() == 2 || sl) begin
                    if (m_pend.size() == 2) begin
                        m_din = {m_pend[0], m_pend[1]};
                    end else begin
                        m_din = {m_pend[0], 32'h0};
                        m_odd = 1'b1;
                    end
                    m_addr = m_ptr;
                    m_ptr  = m_ptr + 1;
                    if (m_cnt != {(ADDR_W+1){1'b1}}) m_cnt = m_cnt + 1;
                    m_we = 1'b1;
                    m_pend.delete();
                    if (sl) m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
            m_done  = 1'b1;
            m_busy  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        m_phase = 0;
        m_pend.delete();
        m_ptr = '0; m_cnt = '0; m_odd = 1'b0; m_busy = 1'b0;
        m_we = 1'b0; m_done = 1'b0; m_addr = '0; m_din = '0;
        #1;
        compare_all();
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; start_addr = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic drain();
        int guard = 0;
        while (m_phase != 0 && guard < 10) begin
            applyStimulus(1'b0, ADDR_W'($urandom), 1'($urandom), $urandom, 1'($urandom));
            guard++;
        end
    endtask

    // Start a burst at sa and stream burst_words with random gaps; optional
    // spurious start requests and a word offered in the start cycle itself.
    task automatic send_burst(input logic [ADDR_W-1:0] sa, input int gap_pct,
                              input bit spam, input bit same_cycle_valid);
        int idx = 0;
        int guard = 0;
        int n = burst_words.size();
        logic sv;
        applyStimulus(1'b1, sa, same_cycle_valid, burst_words[0], n == 1);
        while (idx < n && guard < 50000) begin
            sv = ($urandom_range(99) >= gap_pct);
            applyStimulus(spam && ($urandom_range(3) == 0), ADDR_W'($urandom),
                          sv, burst_words[idx], idx == n - 1);
            if (last_accept) idx++;
            guard++;
        end
        drain();
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // Basic even burst.
        burst_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_burst(10'h010, 0, 1'b0, 1'b0);
        checkOutput("b1_wr_cnt", 64'(wr_cnt), 64'd2);
        checkOutput("b1_odd", 64'(odd), 64'd0);

        // Odd burst.
        burst_words = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        send_burst(10'h020, 0, 1'b0, 1'b0);
        checkOutput("b2_odd", 64'(odd), 64'd1);
        checkOutput("b2_wr_cnt", 64'(wr_cnt), 64'd2);
        checkOutput("b2_din", bram_din, 64'hCCCC0003_00000000);

        // Single word.
        burst_words = '{32'hDEADBEEF};
        send_burst(10'h123, 0, 1'b0, 1'b1);
        checkOutput("b3_din", bram_din, 64'hDEADBEEF_00000000);
        checkOutput("b3_addr", 64'(bram_addr), 64'h123);

        // Address wrap.
        burst_words = '{32'h1, 32'h2, 32'h3, 32'h4};
        send_burst(10'h3FF, 0, 1'b0, 1'b0);
        checkOutput("wrap_addr", 64'(bram_addr), 64'h000);

        // Valid offered while idle is never accepted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, $urandom, 1'b1);

        // Backpressure pattern 1,0,0,1 with start requests mid-burst.
        applyStimulus(1'b1, 10'h040, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h0BAD0001, 1'b0);
        applyStimulus(1'b1, 10'h200, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 10'h201, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h0BAD0002, 1'b1);
        checkOutput("bp_we", 64'(bram_we), 64'd1);
        checkOutput("bp_addr", 64'(bram_addr), 64'h040);
        drain();

        // Reset after one accepted word; then a clean 2-word burst.
        applyStimulus(1'b1, 10'h077, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h5757AAAA, 1'b0);
        apply_reset();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, $urandom, 1'b0);
        burst_words = '{32'h0000CAFE, 32'h0000F00D};
        send_burst(10'h005, 0, 1'b0, 1'b0);
        checkOutput("rst_din", bram_din, 64'h0000CAFE_0000F00D);
        checkOutput("rst_cnt", 64'(wr_cnt), 64'd1);

        // Randomized bursts with gaps and stray start requests.
        for (int b = 0; b < 40; b++) begin
            int n = $urandom_range(1, 9);
            burst_words.delete();
            for (int i = 0; i < n; i++) burst_words.push_back($urandom);
            send_burst(ADDR_W'($urandom), 30, 1'b1, 1'($urandom));
            if ($urandom_range(3) == 0) applyStimulus(1'b0, '0, 1'($urandom), $urandom, 1'b0);
        end

        // Long burst so the write counter saturates.
        burst_words.delete();
        for (int i = 0; i < 4100; i++) burst_words.push_back($urandom);
        send_burst(ADDR_W'($urandom), 0, 1'b0, 1'b0);
        checkOutput("sat_cnt", 64'(wr_cnt), 64'h7FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
